// File: rtl/fifo_deq_skid_pkg.sv
// -----------------------------------------------------------------------------
// fifo_deq_skid_pkg
// Shared definitions for the FIFO dequeue skid adapter:
//   - skid_state_t : buffer state, encoded so the value equals the entry count
//   - DEFAULT_WIDTH / DEFAULT_CNT_W : default data and beat-counter widths
// -----------------------------------------------------------------------------
package fifo_deq_skid_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // nothing buffered
      ONE   = 2'd1,   // main holds the head entry
      FULL2 = 2'd2    // main holds the head, skid holds the next entry
   } skid_state_t;

   localparam int DEFAULT_WIDTH = 64;
   localparam int DEFAULT_CNT_W = 16;

endpackage : fifo_deq_skid_pkg

// File: rtl/fifo_deq_skid.sv
// -----------------------------------------------------------------------------
// fifo_deq_skid
// Drains a FIFO through its EMPTY_N / D_OUT / DEQ handshake and presents the
// data downstream as a valid/ready stream. A two-entry registered skid buffer
// (main + skid) lets src_deq depend only on src_empty_n and local state, so
// there is no combinational path from out_ready back into the FIFO.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RST          synchronous active-high reset
//   CLR          synchronous flush, drops buffered entries
//   src_empty_n  FIFO has data (EMPTY_N)
//   src_d        FIFO head data (D_OUT)
//   src_deq      dequeue strobe to the FIFO (DEQ)
//   out_valid    downstream data valid
//   out_data     downstream data (always the main register)
//   out_ready    downstream accepts
//   occupancy    entries held: 0, 1 or 2
//   beat_count   delivered beats, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_deq_skid
   import fifo_deq_skid_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             src_empty_n,
   input  logic [WIDTH-1:0] src_d,
   output logic             src_deq,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] beat_count
);

   skid_state_t      state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             take;
   logic             give;

   // Dequeue only while there is room for one more entry. out_ready is
   // deliberately absent: a slot is guaranteed whenever state != FULL2.
   assign src_deq   = src_empty_n && !CLR && !RST && (state != FULL2);
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;

   assign take = src_deq;
   assign give = out_valid && out_ready;

   always_comb begin
      // NOTE: default assignment first so every path drives occupancy and no latch is inferred.
      occupancy = 2'd0;
      case (state)
         EMPTY:   occupancy = 2'd0;
         ONE:     occupancy = 2'd1;
         FULL2:   occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         beat_count <= '0;
      end else begin
         // A beat accepted downstream counts even when a flush lands on it.
         if (give) beat_count <= beat_count + CNT_W'(1);

         // NOTE: a flush only resets the state; main/skid keep stale data,
         // which is never visible because out_valid is low in EMPTY.
         if (CLR) begin
            state <= EMPTY;
         end else begin
            case (state)
               EMPTY: begin
                  if (take) begin
                     state  <= ONE;
                     main_q <= src_d;
                  end
               end
               ONE: begin
                  if (take && give) begin
                     main_q <= src_d;
                  end else if (take) begin
                     // Downstream stalled: park the newer entry behind main.
                     state  <= FULL2;
                     skid_q <= src_d;
                  end else if (give) begin
                     state <= EMPTY;
                  end
               end
               FULL2: begin
                  // take cannot occur here; skid moves up once main leaves.
                  if (give) begin
                     state  <= ONE;
                     main_q <= skid_q;
                  end
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

   // Simulation-only sanity checks; neither can fire by construction.
   a_deq_needs_data : assert property (@(posedge CLK) disable iff (RST)
      src_deq |-> src_empty_n)
      else $warning("fifo_deq_skid: src_deq asserted while src_empty_n=0");

   a_no_full_to_empty : assert property (@(posedge CLK)
      (state == FULL2 && !CLR && !RST) |=> (state != EMPTY))
      else $warning("fifo_deq_skid: occupancy went 2->0 without CLR/RST");

endmodule : fifo_deq_skid

// File: tb/tb_fifo_deq_skid.sv
// -----------------------------------------------------------------------------
// tb_fifo_deq_skid
// Self-checking bench for fifo_deq_skid (CNT_W=4 so the counter wrap is cheap
// to reach). Inputs change just after the falling edge; outputs are compared
// one time unit later, well before the next rising edge. The reference model
// is a plain queue of buffered entries plus a beat counter.
// -----------------------------------------------------------------------------
module tb_fifo_deq_skid;

   localparam int WIDTH = 64;
   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             CLR;
   logic             src_empty_n;
   logic [WIDTH-1:0] src_d;
   logic             src_deq;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] beat_count;

   fifo_deq_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .CLR         (CLR),
      .src_empty_n (src_empty_n),
      .src_d       (src_d),
      .src_deq     (src_deq),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .occupancy   (occupancy),
      .beat_count  (beat_count)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: entries held, in delivery order, and beat tally.
   logic [WIDTH-1:0] mq[$];
   int               mcnt  = 0;
   int               mgive = 0;

   typedef struct {
      logic             clr;
      logic             ne;
      logic [WIDTH-1:0] d;
      logic             rdy;
      logic             e_deq;
      logic             e_valid;
      logic [WIDTH-1:0] e_data;
      logic [1:0]       e_occ;
      logic [CNT_W-1:0] e_cnt;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mkv(logic clr, logic ne, logic [WIDTH-1:0] d, logic rdy,
                                logic e_deq, logic e_valid, logic [WIDTH-1:0] e_data,
                                logic [1:0] e_occ, logic [CNT_W-1:0] e_cnt);
      vec_t v;
      v.clr = clr; v.ne = ne; v.d = d; v.rdy = rdy;
      v.e_deq = e_deq; v.e_valid = e_valid; v.e_data = e_data;
      v.e_occ = e_occ; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic clr, input logic ne,
                        input logic [WIDTH-1:0] d, input logic rdy);
      RST = rst; CLR = clr; src_empty_n = ne; src_d = d; out_ready = rdy;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic step();
      logic take;
      logic give;
      @(posedge CLK);
      take = src_empty_n && !CLR && !RST && (mq.size() < 2);
      give = (mq.size() > 0) && out_ready;
      if (RST) begin
         mq.delete();
         mcnt  = 0;
         mgive = 0;
      end else begin
         if (give) begin
            mcnt  = (mcnt + 1) % (1 << CNT_W);
            mgive = mgive + 1;
         end
         if (CLR) begin
            mq.delete();
         end else begin
            if (give) void'(mq.pop_front());
            if (take) mq.push_back(src_d);
         end
      end
      @(negedge CLK);
   endtask

   task automatic model_compare();
      logic e_deq;
      e_deq = src_empty_n && !CLR && !RST && (mq.size() < 2);
      check("deq", {63'd0, src_deq}, {63'd0, e_deq});
      check("valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
      check("occ", {62'd0, occupancy}, 64'(mq.size()));
      check("cnt", {60'd0, beat_count}, 64'(mcnt));
      if (mq.size() > 0) check("data", out_data, mq[0]);
   endtask

   // One model-checked cycle.
   task automatic cycle(input logic rst, input logic clr, input logic ne,
                        input logic [WIDTH-1:0] d, input logic rdy);
      drive(rst, clr, ne, d, rdy);
      #1;
      model_compare();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Stream 0x11..0x33, then backpressure fill with A, B, C.
      tbl[0]  = mkv(0, 0, 64'h0,  0, 0, 0, 64'h0,  2'd0, 4'd0);
      tbl[1]  = mkv(0, 1, 64'h11, 1, 1, 0, 64'h0,  2'd0, 4'd0);
      tbl[2]  = mkv(0, 1, 64'h22, 1, 1, 1, 64'h11, 2'd1, 4'd0);
      tbl[3]  = mkv(0, 1, 64'h33, 1, 1, 1, 64'h22, 2'd1, 4'd1);
      tbl[4]  = mkv(0, 0, 64'h0,  1, 0, 1, 64'h33, 2'd1, 4'd2);
      tbl[5]  = mkv(0, 0, 64'h0,  1, 0, 0, 64'h0,  2'd0, 4'd3);
      tbl[6]  = mkv(0, 0, 64'h0,  1, 0, 0, 64'h0,  2'd0, 4'd3);
      tbl[7]  = mkv(0, 1, 64'hA,  0, 1, 0, 64'h0,  2'd0, 4'd3);
      tbl[8]  = mkv(0, 1, 64'hB,  0, 1, 1, 64'hA,  2'd1, 4'd3);
      tbl[9]  = mkv(0, 1, 64'hC,  0, 0, 1, 64'hA,  2'd2, 4'd3);
      tbl[10] = mkv(0, 1, 64'hC,  0, 0, 1, 64'hA,  2'd2, 4'd3);
      tbl[11] = mkv(0, 1, 64'hC,  1, 0, 1, 64'hA,  2'd2, 4'd3);
      tbl[12] = mkv(0, 1, 64'hC,  1, 1, 1, 64'hB,  2'd1, 4'd4);
      tbl[13] = mkv(0, 0, 64'h0,  1, 0, 1, 64'hC,  2'd1, 4'd5);
      tbl[14] = mkv(0, 0, 64'h0,  0, 0, 0, 64'h0,  2'd0, 4'd6);

      drive(1, 0, 0, '0, 0);
      step();
      step();

      for (int i = 0; i < 15; i++) begin
         drive(0, tbl[i].clr, tbl[i].ne, tbl[i].d, tbl[i].rdy);
         #1;
         check($sformatf("tbl%0d_deq", i),   {63'd0, src_deq},    {63'd0, tbl[i].e_deq});
         check($sformatf("tbl%0d_valid", i), {63'd0, out_valid},  {63'd0, tbl[i].e_valid});
         check($sformatf("tbl%0d_occ", i),   {62'd0, occupancy},  {62'd0, tbl[i].e_occ});
         check($sformatf("tbl%0d_cnt", i),   {60'd0, beat_count}, {60'd0, tbl[i].e_cnt});
         if (tbl[i].e_valid) check($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
         step();
      end

      // Independence: src_deq must not react to out_ready within a cycle.
      cycle(1, 0, 0, '0, 0);
      cycle(0, 0, 1, 64'hD1, 0);
      drive(0, 0, 1, 64'hD2, 0);
      #1; check("indep_one_r0", {63'd0, src_deq}, 64'd1);
      out_ready = 1'b1;
      #1; check("indep_one_r1", {63'd0, src_deq}, 64'd1);
      out_ready = 1'b0;
      step();
      drive(0, 0, 1, 64'hD3, 0);
      #1; check("indep_full_r0", {63'd0, src_deq}, 64'd0);
      out_ready = 1'b1;
      #1; check("indep_full_r1", {63'd0, src_deq}, 64'd0);
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 64'hD3 + 64'(i), 1'(i % 2));

      // Flush while FULL2 with the source non-empty and downstream stalled.
      cycle(1, 0, 0, '0, 0);
      cycle(0, 0, 1, 64'hE1, 0);
      cycle(0, 0, 1, 64'hE2, 0);
      cycle(0, 1, 1, 64'hE3, 0);
      check("clr_occ", {62'd0, occupancy}, 64'd0);
      check("clr_valid", {63'd0, out_valid}, 64'd0);
      check("clr_cnt", {60'd0, beat_count}, 64'd0);
      cycle(0, 0, 1, 64'hE3, 1);
      check("clr_head_kept", out_data, 64'hE3);
      cycle(0, 0, 0, '0, 1);

      // Reset mid-stream with occupancy 2 and five beats delivered.
      cycle(1, 0, 0, '0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 64'h50 + 64'(i), 1);
      cycle(0, 0, 0, '0, 1);
      cycle(0, 0, 1, 64'h60, 0);
      cycle(0, 0, 1, 64'h61, 0);
      check("pre_rst_occ", {62'd0, occupancy}, 64'd2);
      check("pre_rst_cnt", {60'd0, beat_count}, 64'd5);
      cycle(1, 0, 1, 64'h62, 1);
      check("rst_occ", {62'd0, occupancy}, 64'd0);
      check("rst_cnt", {60'd0, beat_count}, 64'd0);
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      cycle(0, 0, 1, 64'h77, 1);
      check("resume_data", out_data, 64'h77);
      cycle(0, 0, 0, '0, 1);

      // Counter wrap: 17 beats through a 4-bit counter.
      cycle(1, 0, 0, '0, 0);
      for (int i = 0; i < 19; i++) begin
         cycle(0, 0, (i < 17), 64'h100 + 64'(i), 1);
         if (mgive == 15) check("wrap_15", {60'd0, beat_count}, 64'd15);
         if (mgive == 16) check("wrap_16", {60'd0, beat_count}, 64'd0);
         if (mgive == 17) check("wrap_17", {60'd0, beat_count}, 64'd1);
      end

      // Random traffic against the queue model.
      cycle(1, 0, 0, '0, 0);
      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 3) != 0),
               {$urandom, $urandom},
               ($urandom_range(0, 2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_deq_skid

// File: doc/fifo_deq_skid.md
Name: fifo_deq_skid

Overview:
- Read-side adapter that drains a depth-1/depth-N FIFO through its EMPTY_N / D_OUT / DEQ handshake.
- Presents the drained data downstream as a valid/ready stream.
- Contains a 2-entry registered skid buffer, so the FIFO's DEQ depends only on local state and never on downstream ready. This breaks the combinational DEQ->FULL_N path of the single-entry FIFOs.
- Sits between core pipeline-stage FIFOs and consumers that cannot tolerate combinational ready paths.

Parameters:
- WIDTH, 64, data width in bits.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- CLR  in  1  synchronous flush; discards buffered entries.
- src_empty_n  in  1  FIFO has data (FIFO EMPTY_N).
- src_d  in  WIDTH  FIFO head data (FIFO D_OUT).
- src_deq  out  1  dequeue strobe to the FIFO (FIFO DEQ).
- out_valid  out  1  downstream data valid.
- out_data  out  WIDTH  downstream data.
- out_ready  in  1  downstream accepts.
- occupancy  out  2  entries held: 0, 1 or 2.
- beat_count  out  CNT_W  count of delivered beats; wraps modulo 2^CNT_W.

Behaviour:
- Reset (RST=1 at the edge):
  - state=EMPTY, main=0, skid=0, beat_count=0.
  - Outputs after reset: out_valid=0, src_deq=0, occupancy=0.
- Combinational outputs:
  - src_deq = src_empty_n && !CLR && !RST && (state != FULL2). It is a function of src_empty_n and registered state only, with no path from out_ready.
  - out_valid = (state != EMPTY).
  - out_data = main.
  - occupancy = 0 / 1 / 2 for EMPTY / ONE / FULL2.
- Event definitions: take = src_deq; give = out_valid && out_ready.
- States and transitions, evaluated when CLR=0:
  - EMPTY: take -> ONE, main<=src_d. Otherwise stay EMPTY. Note give is impossible in EMPTY.
  - ONE, take && give -> ONE, main<=src_d.
  - ONE, take && !give -> FULL2, skid<=src_d, main held.
  - ONE, !take && give -> EMPTY.
  - ONE, neither -> hold.
  - FULL2: take is impossible. give -> ONE, main<=skid. Otherwise hold.
- Latency and throughput:
  - Data dequeued in cycle N appears on out_data in cycle N+1.
  - Sustained throughput is 1 beat/cycle while src_empty_n=1 and out_ready=1.
- Ordering: strict FIFO. skid is always older-than-next-source and younger than main.
- CLR:
  - Takes priority over all transitions: next state=EMPTY.
  - src_deq is forced 0 in the CLR cycle, so no source entry is consumed.
  - A give in the CLR cycle still counts in beat_count; the downstream saw valid && ready.
  - Data registers are not cleared.
- RST mid-operation: RST wins over CLR and all events. Buffered data is lost and the counter is zeroed.
- beat_count: +1 on every give; wraps from all-ones to 0.
- Boundary conditions:
  - out_ready held 0 with the source non-empty: fill to FULL2, then src_deq=0.
  - out_ready asserted while EMPTY: no effect.
- Assertions (simulation only):
  - Warn on src_deq while src_empty_n=0 (cannot occur by construction).
  - Warn on occupancy transition 2->0 without CLR/RST.

Decomposition:
- Shared package holds:
  - state encoding typedef (EMPTY=2'd0, ONE=2'd1, FULL2=2'd2);
  - default WIDTH/CNT_W constants.
- Single module; no sub-module needed. The skid register pair is small enough to keep inline.

Test Plan:
1. Stream, no backpressure: after reset, source supplies 0x11,0x22,0x33 back-to-back with out_ready=1 -> src_deq high 3 consecutive cycles; out_data 0x11,0x22,0x33 on the 3 following cycles; occupancy stays 1; beat_count=3.
2. Backpressure fill: out_ready=0, source holds 0xA,0xB,0xC -> src_deq high two cycles then low; occupancy 1 then 2. Raise out_ready -> out_data 0xA then 0xB; src_deq resumes; 0xC delivered third; order preserved.
3. Independence check: toggle out_ready each cycle in FULL2 -> src_deq never asserts in a cycle where state=FULL2. src_deq shows no same-cycle response to out_ready.
4. CLR in FULL2 with source non-empty and out_ready=0 -> next cycle occupancy=0, out_valid=0; src_deq=0 during the CLR cycle; source head is not consumed; beat_count unchanged.
5. Reset mid-stream: occupancy=2, beat_count=5, assert RST one cycle -> occupancy=0, beat_count=0, out_valid=0. Normal streaming resumes on the next cycle.
6. Counter wrap: CNT_W=4; deliver 17 beats -> beat_count reads 15 after 15 beats, 0 after 16, 1 after 17.
